// File: rtl/nlfsr_search_scheduler_pkg.sv
// nlfsr_search_scheduler_pkg: shared types and constants for the NLFSR tap-pair search scheduler
package nlfsr_search_scheduler_pkg;
  localparam int TAP_W = 5;
  typedef enum logic [1:0] {U_FREE, U_RUNNING, U_HOLD} unit_state_e;
  typedef enum logic [2:0] {D_IDLE, D_SCAN, D_UNRST, D_TAP_A, D_TAP_B, D_DRAIN} disp_state_e;
  function automatic int period(input int size);
    return (1 << size) - 1;
  endfunction
  function automatic int timeout_limit(input int size, input int margin);
    return period(size) + margin;
  endfunction
  function automatic int timeout_w(input int size, input int margin);
    return $clog2(timeout_limit(size, margin) + 1);
  endfunction
endpackage

// File: rtl/nlfsr_search_scheduler_if.sv
// nlfsr_search_scheduler_if: host, tester-array and result signals of the search scheduler
interface nlfsr_search_scheduler_if #(
  parameter int NUM_UNITS = 4
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [NUM_UNITS-1:0] u_res;
  logic [NUM_UNITS-1:0] u_ena;
  logic [NUM_UNITS-1:0] u_take_coef;
  logic [7:0]           u_coef;
  logic [NUM_UNITS-1:0] u_found;
  logic [NUM_UNITS-1:0] u_failure;
  logic                 r_valid;
  logic                 r_ready;
  logic [15:0]          r_taps;
  logic [15:0]          n_tested;
  logic [15:0]          n_found;
  logic [7:0]           n_timeout;
  modport master (
    input  start, u_found, u_failure, r_ready,
    output busy, done, u_res, u_ena, u_take_coef, u_coef, r_valid, r_taps, n_tested, n_found, n_timeout
  );
  modport slave (
    output start, u_found, u_failure, r_ready,
    input  busy, done, u_res, u_ena, u_take_coef, u_coef, r_valid, r_taps, n_tested, n_found, n_timeout
  );
endinterface

// File: rtl/nlfsr_search_scheduler_unit_tracker.sv
// nlfsr_search_scheduler_unit_tracker: one tester's state, loaded tap pair and hang timer
module nlfsr_search_scheduler_unit_tracker
  import nlfsr_search_scheduler_pkg::*;
#(
  parameter int CW    = 25,
  parameter int LIMIT = 16777223
) (
  input  logic        clk,
  input  logic        res,
  input  logic        load,
  input  logic        to_hold,
  input  logic        to_free,
  input  logic [15:0] pair_in,
  output unit_state_e state,
  output logic [15:0] pair,
  output logic        expired
);
  logic [CW-1:0] cnt;
  assign expired = state == U_RUNNING && cnt == CW'(LIMIT);
  always_ff @(posedge clk) begin
    if (res) begin
      state <= U_FREE;
      cnt   <= '0;
      pair  <= '0;
    end else if (load) begin
      state <= U_RUNNING;
      cnt   <= '0;
      pair  <= pair_in;
    end else if (to_hold) begin
      state <= U_HOLD;
    end else if (to_free) begin
      state <= U_FREE;
    end else if (state == U_RUNNING && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/nlfsr_search_scheduler.sv
// nlfsr_search_scheduler: enumerates (a,b) tap pairs, loads them into free testers and collects verdicts
module nlfsr_search_scheduler
  import nlfsr_search_scheduler_pkg::*;
#(
  parameter int SIZE      = 24,
  parameter int NUM_UNITS = 4,
  parameter int MARGIN    = 8
) (
  input logic clk,
  input logic res,
  nlfsr_search_scheduler_if.master bus
);
  localparam int LIMIT = timeout_limit(SIZE, MARGIN);
  localparam int CW = timeout_w(SIZE, MARGIN);
  localparam int KW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  localparam logic [TAP_W-1:0] A_LAST = TAP_W'(SIZE - 2);
  localparam logic [TAP_W-1:0] B_LAST = TAP_W'(SIZE - 1);
  disp_state_e state, state_n;
  unit_state_e ust [NUM_UNITS];
  logic [15:0] upair [NUM_UNITS];
  logic [NUM_UNITS-1:0] expired, load, to_hold, to_free, free_m, flag_m, hold_m;
  logic [TAP_W-1:0] a, b;
  logic [KW-1:0] k, k_free, k_svc, k_rel;
  logic exhausted, any_svc, any_hold, take, svc_found, svc_fail, tmo, loading, rv;
  logic [1:0] inc_t;
  logic [15:0] taps, n_tested, n_found;
  logic [7:0] n_timeout;
  assign loading = state == D_TAP_A || state == D_TAP_B;
  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    nlfsr_search_scheduler_unit_tracker #(.CW(CW), .LIMIT(LIMIT)) u_trk (
      .clk     (clk),
      .res     (res),
      .load    (load[i]),
      .to_hold (to_hold[i]),
      .to_free (to_free[i]),
      .pair_in ({8'(b), 8'(a)}),
      .state   (ust[i]),
      .pair    (upair[i]),
      .expired (expired[i])
    );
    assign free_m[i]  = ust[i] == U_FREE;
    assign hold_m[i]  = ust[i] == U_HOLD;
    assign flag_m[i]  = ust[i] == U_RUNNING && (bus.u_found[i] || bus.u_failure[i] || expired[i]);
    assign load[i]    = state == D_TAP_B && k == KW'(i);
    assign to_hold[i] = any_svc && k_svc == KW'(i) && svc_found;
    assign to_free[i] = (any_svc && k_svc == KW'(i) && !svc_found) || (take && k_rel == KW'(i));
    assign bus.u_res[i]       = res || (state == D_UNRST && k == KW'(i));
    assign bus.u_ena[i]       = !res && (ust[i] != U_FREE || (loading && k == KW'(i)));
    assign bus.u_take_coef[i] = !res && loading && k == KW'(i);
  end
  // Release order among held units follows enumeration order, keyed {a,b}
  always_comb begin
    k_free = '0;
    k_svc  = '0;
    k_rel  = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (free_m[i]) k_free = KW'(i);
      if (flag_m[i]) k_svc = KW'(i);
    end
    for (int i = 0; i < NUM_UNITS; i++)
      if (hold_m[i] && (!hold_m[k_rel] ||
          {upair[i][7:0], upair[i][15:8]} < {upair[k_rel][7:0], upair[k_rel][15:8]}))
        k_rel = KW'(i);
  end
  assign any_svc   = |flag_m;
  assign any_hold  = |hold_m;
  assign svc_found = bus.u_found[k_svc];
  assign svc_fail  = bus.u_failure[k_svc];
  assign tmo       = any_svc && !svc_found && !svc_fail;
  assign take      = any_hold && (!rv || bus.r_ready);
  assign inc_t     = {1'b0, any_svc && !svc_found} + {1'b0, take};
  always_comb begin
    state_n = state;
    case (state)
      D_IDLE:  state_n = bus.start ? D_SCAN : D_IDLE;
      D_SCAN:  state_n = exhausted ? D_DRAIN : (|free_m) ? D_UNRST : D_SCAN;
      D_UNRST: state_n = D_TAP_A;
      D_TAP_A: state_n = D_TAP_B;
      D_TAP_B: state_n = D_SCAN;
      D_DRAIN: state_n = (&free_m && !rv) ? D_IDLE : D_DRAIN;
      default: state_n = D_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= D_IDLE;
      a         <= '0;
      b         <= '0;
      k         <= '0;
      exhausted <= 1'b0;
      rv        <= 1'b0;
      taps      <= '0;
      n_tested  <= '0;
      n_found   <= '0;
      n_timeout <= '0;
    end else begin
      state <= state_n;
      if (state == D_SCAN) k <= k_free;
      if (state == D_TAP_B) begin
        if (b != B_LAST) b <= b + TAP_W'(1);
        else if (a == A_LAST) exhausted <= 1'b1;
        else begin
          a <= a + TAP_W'(1);
          b <= a + TAP_W'(2);
        end
      end
      if (take) begin
        rv   <= 1'b1;
        taps <= upair[k_rel];
      end else if (bus.r_ready) rv <= 1'b0;
      if (state == D_IDLE && bus.start) begin
        a         <= TAP_W'(1);
        b         <= TAP_W'(2);
        exhausted <= 1'b0;
        n_tested  <= '0;
        n_found   <= '0;
        n_timeout <= '0;
      end else begin
        n_tested  <= n_tested > 16'hFFFF - 16'(inc_t) ? 16'hFFFF : n_tested + 16'(inc_t);
        n_found   <= take && n_found != 16'hFFFF ? n_found + 16'd1 : n_found;
        n_timeout <= tmo && n_timeout != 8'hFF ? n_timeout + 8'd1 : n_timeout;
      end
    end
  end
  assign bus.busy      = !res && state != D_IDLE;
  assign bus.done      = !res && state == D_DRAIN && &free_m && !rv;
  assign bus.u_coef    = loading && !res ? 8'(state == D_TAP_B ? b : a) : 8'd0;
  assign bus.r_valid   = rv && !res;
  assign bus.r_taps    = taps;
  assign bus.n_tested  = n_tested;
  assign bus.n_found   = n_found;
  assign bus.n_timeout = n_timeout;
endmodule
